// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch front end: req/ack memory port, prefetch FIFO, redirect flush.
// Define PREFETCH_STATS_EN to add the stat_delivered / stat_discarded counters.
module pipeline_fetch_unit #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata,
  output logic                         fetch_valid,
  output logic [PC_WIDTH-1:0]          fetch_pc,
  output logic [INSTR_WIDTH-1:0]       fetch_instruction,
  output logic                         fetch_flush,
  output logic [$clog2(FIFO_DEPTH):0]  buffer_count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]                  stat_delivered,
  output logic [7:0]                   stat_discarded
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StFetch, StWait, StDrain} state_e;

  state_e                 r_state;
  logic [PC_WIDTH-1:0]    r_next_pc;
  logic [PC_WIDTH-1:0]    r_pc_mem    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
  logic [PtrW-1:0]        r_rd_ptr;
  logic [PtrW-1:0]        r_wr_ptr;
  logic [CntW-1:0]        r_count;

  logic w_push;
  logic w_pop;

  assign w_push = (r_state == StWait) && imem_ack && !redirect_valid;
  assign w_pop  = fetch_valid && !stall && !redirect_valid;

  // Request FSM; imem_req/imem_addr are held stable until the ack is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StFetch;
      imem_req  <= 1'b0;
      imem_addr <= PC_WIDTH'(RESET_PC);
      r_next_pc <= PC_WIDTH'(RESET_PC);
    end else begin
      unique case (r_state)
        StFetch: begin
          if (redirect_valid) begin
            r_next_pc <= redirect_pc;
          end else if (r_count < CntW'(FIFO_DEPTH)) begin
            imem_req  <= 1'b1;
            imem_addr <= r_next_pc;
            r_state   <= StWait;
          end
        end
        StWait: begin
          if (imem_ack) begin
            imem_req  <= 1'b0;
            r_state   <= StFetch;
            r_next_pc <= redirect_valid ? redirect_pc : imem_addr + PC_WIDTH'(1);
          end else if (redirect_valid) begin
            r_next_pc <= redirect_pc;
            r_state   <= StDrain;
          end
        end
        StDrain: begin
          if (redirect_valid) begin
            r_next_pc <= redirect_pc;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            r_state  <= StFetch;
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // Payload storage needs no reset; an empty FIFO masks it at the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= imem_addr;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  always_comb begin
    fetch_valid       = (r_count != '0);
    fetch_flush       = redirect_valid;
    buffer_count      = r_count;
    fetch_pc          = r_next_pc;
    fetch_instruction = '0;
    if (fetch_valid) begin
      fetch_pc          = r_pc_mem[r_rd_ptr];
      fetch_instruction = r_instr_mem[r_rd_ptr];
    end
  end

`ifdef PREFETCH_STATS_EN
  logic        w_drop_rsp;
  logic [31:0] w_disc_sum;

  assign w_drop_rsp = imem_ack &&
                      ((r_state == StDrain) || ((r_state == StWait) && redirect_valid));
  assign w_disc_sum = 32'(stat_discarded) + 32'(w_drop_rsp) +
                      (redirect_valid ? 32'(r_count) : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_delivered <= '0;
      stat_discarded <= '0;
    end else begin
      if (w_pop && (stat_delivered != 16'hFFFF)) stat_delivered <= stat_delivered + 16'd1;
      stat_discarded <= (w_disc_sum > 32'd255) ? 8'hFF : w_disc_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit: per-cycle vector table plus
// hand-written redirect, wrap-around and reset-abort sequences.
module tb_pipeline_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        fetch_valid;
  logic [7:0]  fetch_pc;
  logic [15:0] fetch_instruction;
  logic        fetch_flush;
  logic [2:0]  buffer_count;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_delivered;
  logic [7:0]  stat_discarded;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  int mem_cnt = 0;

  pipeline_fetch_unit #(
    .FIFO_DEPTH (4),
    .PC_WIDTH   (8),
    .INSTR_WIDTH(16),
    .RESET_PC   (0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_instruction(fetch_instruction),
    .fetch_flush      (fetch_flush),
    .buffer_count     (buffer_count)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_delivered   (stat_delivered),
    .stat_discarded   (stat_discarded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a};
  endfunction

  // Memory: acks on the mem_lat-th negedge that sees imem_req, for one cycle.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || imem_ack) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the first negedge after the first post-reset posedge.
  task automatic do_reset(input logic st);
    rst            = 1'b1;
    stall          = st;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic       stall;
    logic       redir;
    logic [7:0] rpc;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
    logic       e_flush;
  } vec_t;

  vec_t       tbl [20];
  logic [7:0] got_pc [3];
  logic [15:0] got_in [3];
  int         n_got;

  initial begin
    // stall, redir, rpc | req, addr, valid, pc, count, flush
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h00, 3'd4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h00, 3'd4, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h00, 3'd4, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h00, 3'd4, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h01, 3'd3, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02, 3'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h03, 3'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h04, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h05, 3'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h06, 1'b0, 8'h06, 3'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h06, 1'b0, 8'h20, 3'd0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 8'h20, 3'd0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 8'h20, 3'd1, 1'b0};

    // Reset values
    rst            = 1'b1;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   imem_req, 0);
    chk("rst_addr",  imem_addr, 8'h00);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_pc",    fetch_pc, 8'h00);
    chk("rst_instr", fetch_instruction, 16'h0000);
    chk("rst_flush", fetch_flush, 0);
    chk("rst_count", buffer_count, 3'd0);

    // Fill under stall, drain, then redirect on a same-cycle ack
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      stall          = tbl[i].stall;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), fetch_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_pc", i), fetch_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_instr", i), fetch_instruction,
          tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 16'h0000);
      chk($sformatf("v%0d_count", i), buffer_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_flush", i), fetch_flush, tbl[i].e_flush);
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Redirect with 3 entries buffered and no request in flight
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    chk("rd3_count_before", buffer_count, 3'd3);
    chk("rd3_req_before", imem_req, 0);
    chk("rd3_flush", fetch_flush, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rd3_count_after", buffer_count, 3'd0);
    chk("rd3_valid_after", fetch_valid, 0);
    chk("rd3_pc_after", fetch_pc, 8'h40);
    @(negedge clk);
    #1;
    chk("rd3_req", imem_req, 1);
    chk("rd3_addr", imem_addr, 8'h40);

    // Redirect while waiting on a slow ack goes through DRAIN
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    #1;
    chk("dr_ack_same_cycle", imem_ack, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_lat        = 4;
    #1;
    chk("dr_drop_valid", fetch_valid, 0);
    chk("dr_drop_pc", fetch_pc, 8'h05);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    #1;
    chk("dr_req5", imem_req, 1);
    chk("dr_addr5", imem_addr, 8'h05);
    chk("dr_flush", fetch_flush, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("dr_hold%0d_req", k), imem_req, 1);
      chk($sformatf("dr_hold%0d_addr", k), imem_addr, 8'h05);
      @(negedge clk);
    end
    #1;
    chk("dr_after_req", imem_req, 0);
    chk("dr_after_count", buffer_count, 3'd0);
    chk("dr_after_valid", fetch_valid, 0);
    @(negedge clk);
    #1;
    chk("dr_new_req", imem_req, 1);
    chk("dr_new_addr", imem_addr, 8'h80);

    // Sequential fetch across the PC wrap
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_got = 0;
    for (int c = 0; c < 30 && n_got < 3; c++) begin
      #1;
      if (fetch_valid) begin
        got_pc[n_got] = fetch_pc;
        got_in[n_got] = fetch_instruction;
        n_got++;
      end
      @(negedge clk);
    end
    chk("wrap_n_delivered", n_got, 3);
    if (n_got == 3) begin
      chk("wrap_pc0", got_pc[0], 8'hFE);
      chk("wrap_pc1", got_pc[1], 8'hFF);
      chk("wrap_pc2", got_pc[2], 8'h00);
      chk("wrap_instr2", got_in[2], mem_word(8'h00));
    end

    // Reset in the middle of a request drops imem_req at once
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        #1;
        if (imem_req) seen = 1'b1;
        else @(negedge clk);
      end
      chk("abort_req_seen", seen, 1);
      rst = 1'b1;
      #1;
      chk("abort_req", imem_req, 0);
      chk("abort_count", buffer_count, 3'd0);
      chk("abort_addr", imem_addr, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
